// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores feed a small TX FIFO, loads poll status/control,
// and a baud-rate serializer drains the FIFO onto tx_o LSB first.
module mmio_uart_tx #(
   parameter int unsigned        BITNESS      = 32,
   parameter logic [BITNESS-1:0] BASE_ADDR    = 'h0001_0000,
   parameter int unsigned        CLKS_PER_BIT = 16,
   parameter int unsigned        FIFO_AW      = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [BITNESS-1:0] address_i,
   input  logic [BITNESS-1:0] write_data_i,
   input  logic               write_enable_i,
   input  logic               read_en_i,
   output logic [BITNESS-1:0] read_data_o,
   output logic               hit_o,
   output logic               tx_o,
   output logic               busy_o,
   output logic               irq_o
);

   localparam int unsigned       Depth     = 2 ** FIFO_AW;
   localparam int unsigned       BaudW     = $clog2(CLKS_PER_BIT);
   localparam logic [BaudW-1:0]  BaudMax   = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]  CountFull = (FIFO_AW + 1)'(Depth);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [7:0]         r_fifo [Depth];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_overflow;
   logic               r_en;
   logic               r_irq_en;
   state_e             r_state;
   logic [BaudW-1:0]   r_baud;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_tx;

   logic               w_hit;
   logic [1:0]         w_offset;
   logic               w_wr_txdata;
   logic               w_wr_status;
   logic               w_wr_ctrl;
   logic               w_full;
   logic               w_empty;
   logic               w_busy;
   logic               w_push;
   logic               w_pop;
   logic               w_baud_done;
   logic [BITNESS-1:0] w_read_data;
   logic               w_unused;

   assign w_hit       = (address_i[BITNESS-1:4] == BASE_ADDR[BITNESS-1:4]);
   assign w_offset    = address_i[3:2];
   assign w_wr_txdata = w_hit & write_enable_i & (w_offset == 2'd0);
   assign w_wr_status = w_hit & write_enable_i & (w_offset == 2'd1);
   assign w_wr_ctrl   = w_hit & write_enable_i & (w_offset == 2'd2);

   assign w_full      = (r_count == CountFull);
   assign w_empty     = (r_count == '0);
   assign w_busy      = (r_state != StIdle);
   assign w_baud_done = (r_baud == BaudMax);

   // Full is judged on the pre-edge count, so a same-edge pop never rescues a push while full.
   assign w_push = w_wr_txdata & ~w_full;
   assign w_pop  = r_en & ~w_empty &
                   ((r_state == StIdle) | ((r_state == StStop) & w_baud_done));

   assign w_unused = ^{write_data_i[BITNESS-1:8], address_i[1:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_en       <= 1'b0;
         r_irq_en   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         if (w_wr_txdata && w_full) begin
            r_overflow <= 1'b1;
         end else if (w_wr_status && write_data_i[3]) begin
            r_overflow <= 1'b0;
         end
         if (w_wr_ctrl) begin
            r_en     <= write_data_i[0];
            r_irq_en <= write_data_i[1];
         end
      end
   end

   // Storage needs no reset: pointers and count define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wptr] <= write_data_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= StIdle;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            StIdle: begin
               r_baud <= '0;
               if (w_pop) begin
                  r_state <= StStart;
                  r_shift <= r_fifo[r_rptr];
                  r_tx    <= 1'b0;
               end
            end
            StStart: begin
               if (w_baud_done) begin
                  r_baud    <= '0;
                  r_state   <= StData;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            StData: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= StStop;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_tx      <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            StStop: begin
               if (w_baud_done) begin
                  r_baud <= '0;
                  // Chain straight into the next start bit when more data is waiting.
                  if (w_pop) begin
                     r_state <= StStart;
                     r_shift <= r_fifo[r_rptr];
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= StIdle;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      w_read_data = '0;
      if (w_hit && read_en_i) begin
         case (w_offset)
            2'd1: begin
               w_read_data[0]             = w_full;
               w_read_data[1]             = w_empty;
               w_read_data[2]             = w_busy;
               w_read_data[3]             = r_overflow;
               w_read_data[8 +: FIFO_AW+1] = r_count;
            end
            2'd2: begin
               w_read_data[0] = r_en;
               w_read_data[1] = r_irq_en;
            end
            default: w_read_data = '0;
         endcase
      end
   end

   assign read_data_o = w_read_data;
   assign hit_o       = w_hit;
   assign tx_o        = r_tx;
   assign busy_o      = w_busy;
   assign irq_o       = r_irq_en & w_empty & ~w_busy;

endmodule
